// File: rtl/detect_sched.sv
// Round-robin scheduler sharing one symbol detector between two requesters:
// clears the detector, streams the granted burst into it and counts hits.
module detect_sched (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [1:0] req_i,
    input  logic [3:0] len0_i,
    input  logic [3:0] len1_i,
    input  logic [1:0] sym0_i,
    input  logic [1:0] sym1_i,
    output logic [1:0] gnt_o,
    output logic       det_clr_o,
    output logic [1:0] det_num_o,
    input  logic       det_ans_i,
    output logic       done_o,
    output logic       done_id_o,
    output logic [3:0] hit_cnt_o
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLR   = 3'd1;
    localparam logic [2:0] S_FEED  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0] state_q, state_d;
    logic       id_q, id_d;
    logic       last_q, last_d;
    logic [3:0] len_q, len_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] hit_q, hit_d;
    logic       win_s;

    logic [1:0] gnt_q;
    logic       det_clr_q;
    logic       done_q;
    logic       done_id_q;
    logic [3:0] hit_out_q;

    // Next-state logic: arbitration, burst sequencing and hit accumulation
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        last_d  = last_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        hit_d   = hit_q;
        win_s   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_i != 2'b00) begin
                    win_s   = (req_i == 2'b11) ? ~last_q : req_i[1];
                    id_d    = win_s;
                    last_d  = win_s;
                    len_d   = win_s ? len1_i : len0_i;
                    state_d = S_CLR;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CLR: begin
                cnt_d = 4'd0;
                hit_d = 4'd0;
                if (len_q == 4'd0) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_FEED;
                end
            end
            S_FEED: begin
                cnt_d = cnt_q + 4'd1;
                // det_ans lags det_num by one cycle, so the first FEED sample is stale
                if ((cnt_q != 4'd0) && det_ans_i) begin
                    hit_d = hit_q + 4'd1;
                end else begin
                    hit_d = hit_q;
                end
                if (cnt_q == (len_q - 4'd1)) begin
                    state_d = S_DRAIN;
                end else begin
                    state_d = S_FEED;
                end
            end
            S_DRAIN: begin
                if (det_ans_i) begin
                    hit_d = hit_q + 4'd1;
                end else begin
                    hit_d = hit_q;
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, burst context and registered outputs
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            id_q      <= 1'b0;
            last_q    <= 1'b1;
            len_q     <= 4'd0;
            cnt_q     <= 4'd0;
            hit_q     <= 4'd0;
            gnt_q     <= 2'b00;
            det_clr_q <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= 1'b0;
            hit_out_q <= 4'd0;
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            last_q    <= last_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            hit_q     <= hit_d;
            gnt_q     <= (state_d == S_FEED) ? (id_d ? 2'b10 : 2'b01) : 2'b00;
            det_clr_q <= (state_d == S_CLR);
            done_q    <= (state_d == S_DONE);
            done_id_q <= (state_d == S_DONE) ? id_d : 1'b0;
            hit_out_q <= (state_d == S_DONE) ? hit_d : 4'd0;
        end
    end

    // Symbol path: the requester's current symbol passes straight through while granted
    always_comb begin
        if (gnt_q[1]) begin
            det_num_o = sym1_i;
        end else if (gnt_q[0]) begin
            det_num_o = sym0_i;
        end else begin
            det_num_o = 2'b00;
        end
    end

    assign gnt_o     = gnt_q;
    assign det_clr_o = det_clr_q | reset_i;
    assign done_o    = done_q;
    assign done_id_o = done_id_q;
    assign hit_cnt_o = hit_out_q;

endmodule

// File: doc/detect_sched.md
# detect_sched

Two-requester scheduler that shares a single 2-bit symbol sequence detector (a `num`/`ans` counting-style FSM) between two symbol sources. It arbitrates between the sources round-robin and clears the detector before each burst. It streams the granted source's symbols into the detector, counts detector hits over the burst, and returns the count with a one-cycle completion pulse. It sits between the symbol producers and the detector instance.

## Interface
- No parameters; widths are fixed.
- `clk`  in  1  — single clock, rising edge.
- `reset`  in  1  — synchronous, active-high.
- `req`  in  2  — `req[i]` high: requester i has a burst pending. Sampled only in IDLE.
- `len0`, `len1`  in  4 each  — burst length (symbols) for requester 0/1. Sampled with the grant decision; legal 0..15.
- `sym0`, `sym1`  in  2 each  — current symbol of requester 0/1. Must be valid in every cycle that requester's `gnt` bit is high.
- `gnt`  out  2  — one-hot. Requester i must advance to its next symbol after each cycle `gnt[i]`=1.
- `det_clr`  out  1  — synchronous clear to the detector.
- `det_num`  out  2  — symbol to the detector.
- `det_ans`  in  1  — detector output. Registered: the result for the symbol presented in cycle t is visible in cycle t+1.
- `done`  out  1  — one-cycle burst-complete pulse.
- `done_id`  out  1  — requester served. Valid while `done`=1.
- `hit_cnt`  out  4  — number of `det_ans`=1 samples in the burst. Valid while `done`=1.

## Operation
- FSM states: IDLE, CLR, FEED, DRAIN, DONE.
- **IDLE**
  - If `req`≠0, pick a winner, latch its id and `len`, and go to CLR.
  - Arbitration: if only one requester is asserted, it wins. If both are asserted, the winner is the one that is not `last_id`.
  - `last_id` updates on every grant. Its reset value is 1, so requester 0 wins the first tie.
- **CLR**
  - `det_clr`=1 for exactly one cycle. Clear the hit counter and symbol counter.
  - Next state: latched len=0 → DONE; otherwise FEED.
- **FEED**, lasting exactly len cycles:
  - `gnt[id]`=1 and `det_num`=`sym[id]`; the symbol counter increments.
  - From the 2nd FEED cycle onward, sample `det_ans` each cycle and increment `hit_cnt` when it is 1.
  - After the len-th cycle, go to DRAIN.
- **DRAIN**, one cycle:
  - `gnt`=0 and `det_num`=00.
  - Sample `det_ans` once more; this is the result of the last symbol.
  - Go to DONE.
  - Net effect: exactly len samples are taken, one per symbol.
- **DONE**, one cycle:
  - `done`=1, with `done_id` and `hit_cnt` driven from registers.
  - Go to IDLE.
- Outside FEED: `gnt`=00 and `det_num`=00. Outside CLR: `det_clr`=0, except during reset.
- `hit_cnt` ≤ len ≤ 15, so no overflow handling is needed.
- Changes to `req` or `len` after the grant are ignored until the next IDLE.
  - A requester dropping `req` mid-burst does not abort the burst.
- **Reset** (any state, including mid-burst):
  - Next state is IDLE and `last_id`=1.
  - All counters clear.
  - Outputs: `gnt`=00, `det_num`=00, `done`=0, `done_id`=0, `hit_cnt`=0.
  - `det_clr` is driven high combinationally while `reset`=1, so the detector is cleared together with the scheduler.

## Timing
- `req` is seen in IDLE at cycle t. Then:
  - CLR at t+1.
  - FEED at t+2 … t+1+len.
  - DRAIN at t+2+len.
  - DONE at t+3+len.
  - IDLE at t+4+len.
- Latency from request to `done` is len+3 cycles. The minimum burst period is len+4 cycles.
- len=0: CLR at t+1, DONE at t+2 with `hit_cnt`=0, and `gnt` never asserts.
- Both requesters held high continuously: grants alternate 0,1,0,1…
- A request arriving during a busy burst waits. It is served at the first IDLE after the current DONE.

## Test plan
For all scenarios, the bench drives `det_ans` from a stub that outputs 1 in the cycle after every symbol 11 presented on `det_num`, cleared by `det_clr`.

- **Single burst:** reset, then `req`=01 with len0=5 and sym0 sequence 01,01,10,11,11.
  - `gnt`=01 for 5 cycles starting 2 cycles after `req`.
  - `done`=1, `done_id`=0, `hit_cnt`=2 exactly 8 cycles after `req`.
- **Tie and round-robin:** `req`=11 held, len0=len1=3, sym0=11,11,11 and sym1=01,10,01.
  - First `done_id`=0 with `hit_cnt`=3.
  - Next `done_id`=1 with `hit_cnt`=0.
  - Then requester 0 again.
- **Zero length:** `req`=10 with len1=0.
  - `det_clr` pulses once.
  - `done` pulses 2 cycles after `req`, with `done_id`=1, `hit_cnt`=0, and `gnt` staying 00.
- **Last-symbol capture:** len0=1 with sym0=11.
  - `hit_cnt`=1, proving the DRAIN sample is taken.
- **Reset mid-burst:** assert `reset` in the 3rd FEED cycle of a len=6 burst.
  - `det_clr` is high while `reset` is high.
  - Next cycle: `gnt`=00, `done`=0, `hit_cnt`=0.
  - With `req`=11 afterwards, requester 0 wins.
- **Request hold-off:** raise `req[1]` during requester 0's FEED.
  - Requester 1 is granted, with `det_clr` high, exactly 2 cycles after requester 0's `done`.
